// File: rtl/tiny_mips_pkg.sv
// Shared definitions for the tiny_mips core: opcodes, FSM states, instruction
// field positions and immediate sign-extension helpers.
package tiny_mips_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_SRL  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_CP   = 4'h6;
  localparam logic [3:0] OP_CPI  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BLT  = 4'h9;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_LDWB   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_NAND = 2'd1,
    ALU_SRL  = 2'd2
  } aluOp_t;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS_HI   = 8;
  localparam int RS_LO   = 6;
  localparam int RT_HI   = 5;
  localparam int RT_LO   = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM9_HI = 8;

  function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
    return {{(DATA_W-6){v[5]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
    return {{(DATA_W-9){v[8]}}, v};
  endfunction

endpackage

// File: rtl/tiny_mips_alu.sv
// Combinational datapath for tiny_mips: add / nand / logical shift right,
// plus equality and signed less-than flags for the branch unit.
module tiny_mips_alu
  import tiny_mips_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  aluOp_t            op,
  output logic [DATA_W-1:0] y,
  output logic              eq,
  output logic              lt
);
  logic signed [DATA_W-1:0] aS;
  logic signed [DATA_W-1:0] bS;

  assign aS = a;
  assign bS = b;

  always_comb begin
    y = a + b;
    case (op)
      ALU_NAND: y = ~(a & b);
      ALU_SRL:  y = a >> b[3:0];
      default:  y = a + b;
    endcase
  end

  assign eq = (a == b);
  assign lt = (aS < bS);

endmodule

// File: rtl/tiny_mips_core.sv
// Multi-cycle 16-bit core: FETCH -> DECODE -> EXEC (-> LDWB for loads), one
// shared RAM port used for both instruction fetch and data access.
module tiny_mips_core
  import tiny_mips_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       data_fromRAM,
  output logic              wrEn,
  output logic [SIZE-1:0]   addr_toRAM,
  output logic [15:0]       data_toRAM
);
  logic [15:0]     RF [8];
  logic [SIZE-1:0] PC;
  logic [SIZE-1:0] pcNext;
  logic [SIZE-1:0] pcInc;
  logic [SIZE-1:0] pcBranch;
  state_t          st;
  state_t          stNext;
  logic [15:0]     IR;

  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [15:0] imm6Ext;
  logic [15:0] imm9Ext;
  logic [15:0] rdVal;
  logic [15:0] rsVal;
  logic [15:0] rtVal;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic [15:0] aluY;
  logic        aluEq;
  logic        aluLt;
  aluOp_t      aluOp;
  logic        isRType;
  logic        isBranch;
  logic        takeBranch;
  logic        rfWe;
  logic [15:0] rfWdata;

  assign opcode  = IR[OP_HI:OP_LO];
  assign rd      = IR[RD_HI:RD_LO];
  assign rs      = IR[RS_HI:RS_LO];
  assign rt      = IR[RT_HI:RT_LO];
  assign imm6Ext = sext6(IR[IMM6_HI:0]);
  assign imm9Ext = sext9(IR[IMM9_HI:0]);
  assign rdVal   = RF[rd];
  assign rsVal   = RF[rs];
  assign rtVal   = RF[rt];

  assign isRType  = (opcode == OP_ADD) || (opcode == OP_NAND) || (opcode == OP_SRL);
  assign isBranch = (opcode == OP_BEQ) || (opcode == OP_BLT);

  // Branches compare [11:9] against [8:6]; everything else is rs op (rt | imm6).
  assign aluA = isBranch ? rdVal : rsVal;
  assign aluB = isRType ? rtVal : (isBranch ? rsVal : imm6Ext);

  always_comb begin
    aluOp = ALU_ADD;
    if (opcode == OP_NAND) aluOp = ALU_NAND;
    else if (opcode == OP_SRL) aluOp = ALU_SRL;
  end

  tiny_mips_alu #(.DATA_W(16)) uAlu (
    .a  (aluA),
    .b  (aluB),
    .op (aluOp),
    .y  (aluY),
    .eq (aluEq),
    .lt (aluLt)
  );

  assign takeBranch = ((opcode == OP_BEQ) && aluEq) || ((opcode == OP_BLT) && aluLt);
  assign pcInc      = PC + SIZE'(1);
  assign pcBranch   = PC + imm6Ext[SIZE-1:0];

  always_comb begin
    stNext     = st;
    pcNext     = PC;
    rfWe       = 1'b0;
    rfWdata    = aluY;
    wrEn       = 1'b0;
    addr_toRAM = PC;
    data_toRAM = '0;
    case (st)
      S_FETCH:  stNext = S_DECODE;
      S_DECODE: stNext = S_EXEC;
      S_EXEC: begin
        stNext = S_FETCH;
        pcNext = pcInc;
        case (opcode)
          OP_ADD, OP_ADDI, OP_NAND, OP_SRL: rfWe = 1'b1;
          OP_CP: begin
            rfWe    = 1'b1;
            rfWdata = rsVal;
          end
          OP_CPI: begin
            rfWe    = 1'b1;
            rfWdata = imm9Ext;
          end
          // PC holds until the load data is written back in LDWB.
          OP_LD: begin
            addr_toRAM = aluY[SIZE-1:0];
            pcNext     = PC;
            stNext     = S_LDWB;
          end
          OP_ST: begin
            wrEn       = 1'b1;
            addr_toRAM = aluY[SIZE-1:0];
            data_toRAM = rdVal;
          end
          OP_BEQ, OP_BLT: if (takeBranch) pcNext = pcBranch;
          default: ;
        endcase
      end
      S_LDWB: begin
        rfWe    = 1'b1;
        rfWdata = data_fromRAM;
        pcNext  = pcInc;
        stNext  = S_FETCH;
      end
      default: stNext = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_FETCH;
    else     st <= stNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC <= '0;
      IR <= '0;
      for (int i = 0; i < 8; i++) RF[i] <= '0;
    end else begin
      PC <= pcNext;
      if (st == S_DECODE) IR <= data_fromRAM;
      if (rfWe) RF[rd] <= rfWdata;
    end
  end

endmodule

// File: tb/tb_tiny_mips_core.sv
// Bench for tiny_mips_core: external RAM model, instruction-level reference
// model checked every cycle, directed programs and random memory images.
module tb_tiny_mips_core;
  localparam int MEMW = 256;

  logic        clk;
  logic        rst;
  logic [15:0] data_fromRAM;
  logic        wrEn;
  logic [7:0]  addr_toRAM;
  logic [15:0] data_toRAM;

  logic [15:0] mem [MEMW];
  logic [15:0] img [MEMW];
  logic        loadNow;

  logic [15:0] refRF  [8];
  logic [15:0] refMem [MEMW];
  int          refPC;

  int total;
  int bad;
  int cyc;

  tiny_mips_core #(.SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_fromRAM (data_fromRAM),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (loadNow) begin
      for (int i = 0; i < MEMW; i++) mem[i] <= img[i];
    end else if (wrEn) begin
      mem[addr_toRAM] <= data_toRAM;
    end
    data_fromRAM <= mem[addr_toRAM];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] encR(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
  endfunction

  function automatic logic [15:0] encI(input int op, input int rd, input int rs, input int imm);
    return {4'(op), 3'(rd), 3'(rs), 6'(imm)};
  endfunction

  function automatic logic [15:0] encC(input int rd, input int imm);
    return {4'h7, 3'(rd), 9'(imm)};
  endfunction

  function automatic int simm6(input logic [15:0] ins);
    return ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
  endfunction

  function automatic int simm9(input logic [15:0] ins);
    return ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
  endfunction

  // One architectural step of the instruction at refPC.
  task automatic issStep();
    logic [15:0] ins, a, b;
    int op, rd, ea, nextPc;
    ins    = refMem[refPC];
    op     = int'(ins[15:12]);
    rd     = int'(ins[11:9]);
    a      = refRF[ins[8:6]];
    b      = refRF[ins[5:3]];
    ea     = (int'(a) + simm6(ins)) & (MEMW - 1);
    nextPc = (refPC + 1) & (MEMW - 1);
    case (op)
      0: refRF[rd] = a + b;
      1: refRF[rd] = 16'(int'(a) + simm6(ins));
      2: refRF[rd] = ~(a & b);
      3: refRF[rd] = a >> b[3:0];
      4: refRF[rd] = refMem[ea];
      5: refMem[ea] = refRF[rd];
      6: refRF[rd] = a;
      7: refRF[rd] = 16'(simm9(ins));
      8: if (refRF[rd] == a) nextPc = (refPC + simm6(ins)) & (MEMW - 1);
      9: if ($signed(refRF[rd]) < $signed(a)) nextPc = (refPC + simm6(ins)) & (MEMW - 1);
      default: ;
    endcase
    refPC = nextPc;
  endtask

  // Entered just after a negedge with the core in FETCH; returns at the next FETCH.
  task automatic runChecked(input int nInstr, output int cycles);
    logic [15:0] ins, a, rdv;
    int op, ea;
    cycles = 0;
    for (int k = 0; k < nInstr; k++) begin
      ins = refMem[refPC];
      op  = int'(ins[15:12]);
      a   = refRF[ins[8:6]];
      rdv = refRF[ins[11:9]];
      ea  = (int'(a) + simm6(ins)) & (MEMW - 1);
      chk("fetch_st", dut.st, 0);
      chk("fetch_pc", dut.PC, refPC);
      chk("fetch_addr", addr_toRAM, refPC);
      chk("fetch_wr", wrEn, 0);
      for (int r = 0; r < 8; r++) chk($sformatf("rf%0d", r), dut.RF[r], refRF[r]);
      @(negedge clk); cycles++;
      chk("dec_st", dut.st, 1);
      chk("dec_wr", wrEn, 0);
      chk("dec_addr", addr_toRAM, refPC);
      @(negedge clk); cycles++;
      chk("exec_ir", dut.IR, ins);
      chk("exec_wr", wrEn, (op == 5) ? 1 : 0);
      chk("exec_addr", addr_toRAM, (op == 4 || op == 5) ? ea : refPC);
      chk("exec_data", data_toRAM, (op == 5) ? rdv : 16'h0);
      @(negedge clk); cycles++;
      if (op == 4) begin
        chk("ldwb_st", dut.st, 3);
        chk("ldwb_wr", wrEn, 0);
        @(negedge clk); cycles++;
      end
      issStep();
    end
  endtask

  task automatic clearImg();
    for (int i = 0; i < MEMW; i++) img[i] = 16'h0;
  endtask

  // Load img into RAM and the model while rst is high, release after 10 clocks.
  task automatic startProgram();
    for (int i = 0; i < MEMW; i++) refMem[i] = img[i];
    for (int r = 0; r < 8; r++) refRF[r] = 16'h0;
    refPC = 0;
    @(negedge clk);
    rst     = 1'b1;
    loadNow = 1'b1;
    @(negedge clk);
    loadNow = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_pc", dut.PC, 0);
    chk("rst_st", dut.st, 0);
    chk("rst_ir", dut.IR, 0);
    chk("rst_wr", wrEn, 0);
    chk("rst_addr", addr_toRAM, 0);
    chk("rst_data", data_toRAM, 0);
    for (int r = 0; r < 8; r++) chk($sformatf("rst_rf%0d", r), dut.RF[r], 0);
    rst = 1'b0;
  endtask

  initial begin
    int mism;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    loadNow = 1'b0;

    clearImg();
    img[0] = encC(1, 5);
    img[1] = encC(2, -1);
    img[2] = encR(0, 3, 1, 2);
    img[3] = encI(1, 4, 3, -4);
    startProgram();
    runChecked(4, cyc);
    chk("add_r1", dut.RF[1], 16'd5);
    chk("add_r2", dut.RF[2], 16'hFFFF);
    chk("add_r3", dut.RF[3], 16'd4);
    chk("add_r4", dut.RF[4], 16'd0);
    chk("add_cycles", cyc, 12);

    clearImg();
    img[0] = encC(1, 0);
    img[1] = encC(2, 0);
    img[2] = encC(3, 5);
    img[3] = encI(4, 4, 1, 10);
    img[4] = encR(0, 2, 2, 4);
    img[5] = encI(1, 1, 1, 1);
    img[6] = encI(9, 1, 3, -3);
    img[7] = encI(5, 2, 1, 10);
    img[10] = 16'd5; img[11] = 16'd8; img[12] = 16'd15; img[13] = 16'd17; img[14] = 16'd22;
    startProgram();
    runChecked(24, cyc);
    chk("sum_r2", dut.RF[2], 16'd67);
    chk("sum_r1", dut.RF[1], 16'd5);
    chk("sum_mem15", mem[15], 16'd67);
    chk("sum_in_90", (cyc <= 90) ? 1 : 0, 1);

    clearImg();
    img[0] = encC(1, -1);
    img[1] = encC(2, 255);
    img[2] = encR(2, 3, 1, 2);
    img[3] = encI(4, 4, 0, 30);
    img[4] = encC(6, 15);
    img[5] = encR(3, 7, 4, 6);
    img[6] = 16'hFFFF;
    img[30] = 16'h8000;
    startProgram();
    runChecked(3, cyc);
    runChecked(1, cyc);
    chk("ld_cycles", cyc, 4);
    runChecked(3, cyc);
    chk("nand_r3", dut.RF[3], 16'hFF00);
    chk("srl_r7", dut.RF[7], 16'h0001);
    chk("nop_pc", dut.PC, 7);
    chk("nop_r1", dut.RF[1], 16'hFFFF);
    chk("nop_r5", dut.RF[5], 16'h0000);
    chk("nop_r4", dut.RF[4], 16'h8000);

    clearImg();
    img[0] = encC(1, -1);
    img[1] = encC(2, 1);
    img[2] = encI(9, 1, 2, 3);
    img[3] = encC(7, 9);
    img[4] = encC(7, 9);
    img[5] = encI(8, 1, 2, 2);
    img[6] = encC(5, 7);
    startProgram();
    runChecked(3, cyc);
    chk("blt_taken_pc", dut.PC, 5);
    runChecked(1, cyc);
    chk("beq_nt_pc", dut.PC, 6);
    runChecked(1, cyc);
    chk("br_r7", dut.RF[7], 16'd0);
    chk("br_r5", dut.RF[5], 16'd7);

    clearImg();
    img[0] = encI(8, 0, 0, -1);
    startProgram();
    runChecked(1, cyc);
    chk("wrap_pc", dut.PC, 255);

    clearImg();
    img[0]  = encC(1, 16'h55);
    img[1]  = encI(5, 1, 0, 20);
    img[20] = 16'h1234;
    startProgram();
    runChecked(1, cyc);
    @(negedge clk);
    @(negedge clk);
    chk("st_exec_wr", wrEn, 1);
    rst = 1'b1;
    #1;
    chk("abort_wr", wrEn, 0);
    chk("abort_st", dut.st, 0);
    chk("abort_pc", dut.PC, 0);
    chk("abort_r1", dut.RF[1], 0);
    @(posedge clk);
    #1;
    chk("abort_mem20", mem[20], 16'h1234);

    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < MEMW; i++) img[i] = 16'($urandom);
      startProgram();
      runChecked(250, cyc);
      mism = 0;
      for (int i = 0; i < MEMW; i++) if (mem[i] !== refMem[i]) mism++;
      chk("rand_mem", mism, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
